inregistrare: RTL and testbench
===============================

INREGISTRARE -- requirements
Module: inregistrare

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32: data word width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 10: number of storage words; legal range 1..15.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset; asynchronous, active-high.
REQ-005 in_valid  input  1  producer presents a word on in_data.
REQ-006 in_data  input  WIDTH  word to store.
REQ-007 in_ready  output  1  block accepts a word this cycle.
REQ-008 dump_req  input  1  request to play back all stored words.
REQ-009 out_valid  output  1  out_data carries a played-back word.
REQ-010 out_data  output  WIDTH  played-back word, registered.
REQ-011 out_last  output  1  marks the final word of a playback.
REQ-012 count  output  4  number of words currently stored, 0..DEPTH.
REQ-013 full  output  1  high when count == DEPTH.

Function
REQ-014 The block SHALL implement two states: CAPTURE (reset state) and DUMP.
REQ-015 in_ready SHALL be combinational: 1 only when state == CAPTURE, full == 0 and rst == 0.
REQ-016 In CAPTURE, on each edge with in_valid && in_ready, the block SHALL write in_data to mem[wr_ptr], then increment wr_ptr and count by 1.
REQ-017 Offered words while full == 1 or in DUMP SHALL NOT be stored and SHALL NOT change count; the producer holds them.
REQ-018 full SHALL be derived from count only; writes stop at DEPTH with no wrap-around or overwrite.
REQ-019 In CAPTURE, dump_req sampled high with count > 0 at edge k SHALL move the state to DUMP at edge k and set rd_ptr to 0.
REQ-020 dump_req with count == 0 SHALL be ignored; the state SHALL remain CAPTURE.
REQ-021 If dump_req and an accepted write occur at the same edge, the write SHALL complete first and SHALL be included in the playback.
REQ-022 In DUMP, the block SHALL register mem[rd_ptr] into out_data with out_valid = 1 on each edge and increment rd_ptr. The first word SHALL be visible after edge k+1, followed by one word per cycle with no gaps.
REQ-023 out_last SHALL be 1 exactly in the cycle where out_data holds word count-1; otherwise 0.
REQ-024 At the edge after the out_last cycle, the block SHALL set out_valid and out_last to 0, reset count, wr_ptr and rd_ptr to 0, and return to CAPTURE. in_ready SHALL rise in that cycle.
REQ-025 dump_req SHALL be ignored in DUMP. There is no back-pressure on the output; the consumer accepts every out_valid word.
REQ-026 out_data SHALL hold its last value when out_valid == 0.
REQ-027 Playback order SHALL equal capture order: index 0 first.

Reset
REQ-028 While rst is high, the block SHALL immediately force state = CAPTURE, wr_ptr = rd_ptr = count = 0, full = 0, out_valid = 0, out_last = 0, out_data = 0 and in_ready = 0, independent of clk.
REQ-029 Memory contents SHALL NOT be reset. Stored words are unreachable after reset because count == 0.
REQ-030 Reset asserted during DUMP SHALL abort the playback with no further out_valid. After release, the block SHALL be in CAPTURE with count 0.

Verification
REQ-031 Bench: reset, then write 3 words 0x11111111, 0x22222222, 0x33333333 with in_valid held high -> count reaches 3, in_ready stays 1, full = 0.
REQ-032 Bench: write 12 consecutive words 0x00000000..0x0000000B -> only words 0..9 accepted, full = 1 and in_ready = 0 after 10th edge, count = 10.
REQ-033 Bench: after REQ-032, pulse dump_req for one cycle -> 10 consecutive out_valid cycles starting after second edge, out_data 0x0..0x9 in order, out_last only with 0x9, then count = 0, in_ready = 1.
REQ-034 Bench: count = 2, assert dump_req together with a valid word 0xCAFEF00D -> playback has 3 words, last = 0xCAFEF00D with out_last = 1.
REQ-035 Bench: dump_req with count = 0 -> out_valid stays 0, state stays CAPTURE, in_ready stays 1.
REQ-036 Bench: assert rst asynchronously mid-playback (after word 4 of 10) -> out_valid drops before next edge. After release, count = 0, in_ready = 1, and a new dump_req yields no output.

Source files
------------

// File: rtl/inregistrare.sv
// Capture-then-playback buffer: stores up to DEPTH words, then replays them in
// order as a gap-free registered stream when a dump is requested.
module inregistrare #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  input  logic             dump_req,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output logic [3:0]       count,
  output logic             full
);

  typedef enum logic {CAPTURE, DUMP} state_t;

  localparam logic [3:0] DEPTH_C = 4'(DEPTH);

  state_t           r_state, w_next;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [3:0]       r_wr_ptr, r_rd_ptr, r_count;
  logic [WIDTH-1:0] r_out_data;
  logic             r_out_valid, r_out_last;
  logic             w_full, w_wr_en, w_dump_start;

  assign w_full       = (r_count == DEPTH_C);
  assign in_ready     = (r_state == CAPTURE) && !w_full && !rst;
  assign w_wr_en      = in_valid && in_ready;
  assign w_dump_start = (r_state == CAPTURE) && dump_req && (r_count != '0);

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_last  = r_out_last;
  assign count     = r_count;
  assign full      = w_full;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= CAPTURE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      CAPTURE: if (w_dump_start) w_next = DUMP;
      DUMP:    if (r_out_last)   w_next = CAPTURE;
      default: w_next = CAPTURE;
    endcase
  end

  // Storage is deliberately not reset; count == 0 makes stale words unreachable.
  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[r_wr_ptr] <= in_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
    end else begin
      case (r_state)
        CAPTURE: begin
          // A write on the dump edge lands first, so it is part of the playback.
          if (w_wr_en) begin
            r_wr_ptr <= r_wr_ptr + 4'd1;
            r_count  <= r_count + 4'd1;
          end
          if (w_dump_start) r_rd_ptr <= '0;
        end
        DUMP: begin
          if (r_out_last) begin
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_count     <= '0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
          end else begin
            r_out_data  <= r_mem[r_rd_ptr];
            r_out_valid <= 1'b1;
            r_out_last  <= (r_rd_ptr == r_count - 4'd1);
            r_rd_ptr    <= r_rd_ptr + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_inregistrare.sv
// Directed bench for inregistrare: capture, full limit, playback timing,
// dump-with-write, empty dump and asynchronous reset during playback.
module tb_inregistrare;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready;
  logic        dump_req;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_last;
  logic [3:0]  count;
  logic        full;

  int unsigned passed = 0;
  int unsigned total  = 0;
  logic [31:0] exp_q [$];

  inregistrare #(.WIDTH(32), .DEPTH(10)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .dump_req(dump_req), .out_valid(out_valid),
    .out_data(out_data), .out_last(out_last), .count(count), .full(full)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Pulse dump_req across one edge, then expect exp_q word by word.
  task automatic dump_and_play(input string tag);
    int n;
    n = exp_q.size();
    dump_req = 1'b1;
    step();
    dump_req = 1'b0;
    chk({tag, "_k_valid"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_k_ready"}, {31'd0, in_ready}, 32'd0);
    for (int i = 0; i < n; i++) begin
      step();
      chk($sformatf("%s_valid%0d", tag, i), {31'd0, out_valid}, 32'd1);
      chk($sformatf("%s_data%0d", tag, i), out_data, exp_q[i]);
      chk($sformatf("%s_last%0d", tag, i), {31'd0, out_last}, {31'd0, (i == n - 1)});
      chk($sformatf("%s_busy%0d", tag, i), {31'd0, in_ready}, 32'd0);
    end
    step();
    chk({tag, "_end_valid"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_end_last"}, {31'd0, out_last}, 32'd0);
    chk({tag, "_end_count"}, {28'd0, count}, 32'd0);
    chk({tag, "_end_ready"}, {31'd0, in_ready}, 32'd1);
    chk({tag, "_end_hold"}, out_data, exp_q[n - 1]);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; dump_req = 1'b0;
    #3;
    chk("rst_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_count", {28'd0, count}, 32'd0);
    chk("rst_full", {31'd0, full}, 32'd0);
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_data", out_data, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_ready", {31'd0, in_ready}, 32'd1);

    // Three words with in_valid held high.
    in_valid = 1'b1;
    in_data = 32'h11111111; step();
    chk("w3_ready1", {31'd0, in_ready}, 32'd1);
    in_data = 32'h22222222; step();
    chk("w3_ready2", {31'd0, in_ready}, 32'd1);
    in_data = 32'h33333333; step();
    in_valid = 1'b0;
    chk("w3_count", {28'd0, count}, 32'd3);
    chk("w3_ready3", {31'd0, in_ready}, 32'd1);
    chk("w3_full", {31'd0, full}, 32'd0);
    exp_q = '{32'h11111111, 32'h22222222, 32'h33333333};
    dump_and_play("p3");

    // Twelve offered words, only ten fit.
    in_valid = 1'b1;
    for (int i = 0; i < 12; i++) begin
      in_data = i;
      step();
      chk($sformatf("fill_count%0d", i), {28'd0, count}, (i < 10) ? i + 1 : 10);
      chk($sformatf("fill_full%0d", i), {31'd0, full}, {31'd0, (i >= 9)});
      chk($sformatf("fill_ready%0d", i), {31'd0, in_ready}, {31'd0, (i < 9)});
    end
    in_valid = 1'b0;
    exp_q = {};
    for (int i = 0; i < 10; i++) exp_q.push_back(i);
    dump_and_play("p10");

    // Dump together with an accepted write.
    in_valid = 1'b1;
    in_data = 32'hA; step();
    in_data = 32'hB; step();
    chk("dw_count2", {28'd0, count}, 32'd2);
    in_data = 32'hCAFEF00D;
    dump_req = 1'b1;
    step();
    dump_req = 1'b0;
    in_valid = 1'b0;
    chk("dw_count3", {28'd0, count}, 32'd3);
    chk("dw_k_valid", {31'd0, out_valid}, 32'd0);
    exp_q = '{32'hA, 32'hB, 32'hCAFEF00D};
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("dw_valid%0d", i), {31'd0, out_valid}, 32'd1);
      chk($sformatf("dw_data%0d", i), out_data, exp_q[i]);
      chk($sformatf("dw_last%0d", i), {31'd0, out_last}, {31'd0, (i == 2)});
    end
    step();
    chk("dw_end_valid", {31'd0, out_valid}, 32'd0);
    chk("dw_end_ready", {31'd0, in_ready}, 32'd1);

    // Dump with nothing stored is ignored.
    dump_req = 1'b1;
    step();
    dump_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("empty_valid%0d", i), {31'd0, out_valid}, 32'd0);
      chk($sformatf("empty_ready%0d", i), {31'd0, in_ready}, 32'd1);
      chk($sformatf("empty_count%0d", i), {28'd0, count}, 32'd0);
      step();
    end

    // Asynchronous reset in the middle of a ten-word playback.
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_data = 32'h100 + i;
      step();
    end
    in_valid = 1'b0;
    chk("ar_full", {31'd0, full}, 32'd1);
    dump_req = 1'b1;
    step();
    dump_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("ar_data%0d", i), out_data, 32'h100 + i);
    end
    #2 rst = 1'b1;
    #1;
    chk("ar_valid_drop", {31'd0, out_valid}, 32'd0);
    chk("ar_last_drop", {31'd0, out_last}, 32'd0);
    chk("ar_count", {28'd0, count}, 32'd0);
    chk("ar_ready_rst", {31'd0, in_ready}, 32'd0);
    chk("ar_data_rst", out_data, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    step();
    chk("ar_post_count", {28'd0, count}, 32'd0);
    chk("ar_post_ready", {31'd0, in_ready}, 32'd1);
    chk("ar_post_full", {31'd0, full}, 32'd0);
    dump_req = 1'b1;
    step();
    dump_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("ar_nodump_valid%0d", i), {31'd0, out_valid}, 32'd0);
      chk($sformatf("ar_nodump_ready%0d", i), {31'd0, in_ready}, 32'd1);
      step();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
